// File: rtl/mmt_cdc_hs_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : mmt_cdc_hs_ctrl (with helper mmt_sync_single)
//  Brief   : Source-side 2-phase (toggle) req/ack controller for a multi-bit
//            bus crossing into an asynchronous domain. Holds the data bus
//            stable while a transfer is outstanding, synchronises the
//            returning ack, and provides a watchdog plus sticky error flags.
//  Revision: 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  mmt_sync_single : single-bit multi-flop synchroniser
// ----------------------------------------------------------------------------
module mmt_sync_single #(
  parameter int Depth      = 3,
  parameter bit AsyncReset = 1'b1,
  parameter bit AsyncSet   = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  localparam logic c_rst_val = AsyncSet ? 1'b1 : 1'b0;

  logic [Depth-1:0] r_sync;

  generate
    if (AsyncReset) begin : g_async_rst
      // Shift chain, cleared asynchronously so the output is defined during reset
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_sync <= {Depth{c_rst_val}};
        else       r_sync <= {r_sync[Depth-2:0], i_d};
      end
    end else begin : g_sync_rst
      // Shift chain, cleared on the next clock edge while reset is held
      always_ff @(posedge clk) begin
        if (!rstn) r_sync <= {Depth{c_rst_val}};
        else       r_sync <= {r_sync[Depth-2:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_sync[Depth-1];

endmodule

// ----------------------------------------------------------------------------
//  mmt_cdc_hs_ctrl : top-level handshake controller
// ----------------------------------------------------------------------------
module mmt_cdc_hs_ctrl #(
  parameter int DataWidth     = 8,
  parameter int SyncDepth     = 3,
  parameter int TimeoutCycles = 64,
  parameter int CntWidth      = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [DataWidth-1:0] src_data,
  output logic                 xfer_req,
  output logic [DataWidth-1:0] xfer_data,
  input  logic                 xfer_ack,
  output logic                 done,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 proto_err,
  input  logic                 err_clr,
  output logic [CntWidth-1:0]  xfer_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_complete;
  logic                 w_timeout_hit;
  logic                 w_ack_s;
  logic                 r_req;
  logic [DataWidth-1:0] r_data;
  logic                 r_done;
  logic                 r_timeout_err;
  logic                 r_proto_err;
  logic [CntWidth-1:0]  r_cnt;

  // The ack is the only signal crossing in; it touches nothing before this chain
  mmt_sync_single #(
    .Depth      (SyncDepth),
    .AsyncReset (1'b1),
    .AsyncSet   (1'b0)
  ) u_ack_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (xfer_ack),
    .o_q  (w_ack_s)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode: accept in IDLE, complete when the synced ack matches req
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (src_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (w_ack_s == r_req) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Watchdog: counts waiting cycles, saturating at TimeoutCycles-1; a match on
  // the same edge as expiry wins, so no timeout is flagged in that case
  generate
    if (TimeoutCycles > 0) begin : g_wd
      localparam int c_wd_w = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
      localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(TimeoutCycles - 1);
      logic [c_wd_w-1:0] r_wd;

      // Watchdog counter, restarted on every accepted word
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
          r_wd <= '0;
        else if (w_accept)
          r_wd <= '0;
        else if ((r_state == ST_WAIT_ACK) && !w_complete && (r_wd != c_wd_max))
          r_wd <= r_wd + c_wd_w'(1);
      end

      assign w_timeout_hit = (r_state == ST_WAIT_ACK) && !w_complete && (r_wd == c_wd_max);
    end else begin : g_no_wd
      assign w_timeout_hit = 1'b0;
    end
  endgenerate

  // Request toggle, held data bus, done pulse and completion counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req  <= 1'b0;
      r_data <= '0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= w_complete;
      if (w_accept) begin
        r_req  <= ~r_req;
        r_data <= src_data;
      end
      if (w_complete) r_cnt <= r_cnt + CntWidth'(1);
    end
  end

  // Sticky error flags; a set condition outranks a same-cycle clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_timeout_err <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      if (w_timeout_hit)  r_timeout_err <= 1'b1;
      else if (err_clr)   r_timeout_err <= 1'b0;
      if ((r_state == ST_IDLE) && (w_ack_s != r_req)) r_proto_err <= 1'b1;
      else if (err_clr)                               r_proto_err <= 1'b0;
    end
  end

  assign src_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state == ST_WAIT_ACK);
  assign xfer_req    = r_req;
  assign xfer_data   = r_data;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;
  assign proto_err   = r_proto_err;
  assign xfer_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mmt_cdc_hs_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mmt_cdc_hs_ctrl
//  Brief   : Self-checking bench for mmt_cdc_hs_ctrl (table vectors plus
//            hand-written multi-cycle sequences).
//  Revision: 1.0  initial release
// ============================================================================
module tb_mmt_cdc_hs_ctrl;

  logic       clk;
  logic       rstn;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] src_data;
  logic       xfer_req;
  logic [7:0] xfer_data;
  logic       xfer_ack;
  logic       done;
  logic       busy;
  logic       timeout_err;
  logic       proto_err;
  logic       err_clr;
  logic [1:0] xfer_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  logic exp_req;

  mmt_cdc_hs_ctrl #(
    .DataWidth     (8),
    .SyncDepth     (3),
    .TimeoutCycles (8),
    .CntWidth      (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_data    (src_data),
    .xfer_req    (xfer_req),
    .xfer_data   (xfer_data),
    .xfer_ack    (xfer_ack),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .proto_err   (proto_err),
    .err_clr     (err_clr),
    .xfer_cnt    (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       a;
    logic       rdy;
    logic       req;
    logic [7:0] xd;
    logic       dn;
    logic       bsy;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic a,
                              input logic rdy, input logic req, input logic [7:0] xd,
                              input logic dn, input logic bsy, input logic [1:0] cnt);
    vec_t t;
    t.v = v; t.d = d; t.a = a; t.rdy = rdy; t.req = req;
    t.xd = xd; t.dn = dn; t.bsy = bsy; t.cnt = cnt;
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete transfer with an immediately echoing destination
  task automatic do_xfer(input logic [7:0] d, input logic [1:0] exp_cnt);
    int n;
    bit seen;
    src_valid = 1'b1;
    src_data  = d;
    tick();
    exp_req   = ~exp_req;
    src_valid = 1'b0;
    src_data  = 8'h00;
    chk("xfer_busy", {31'd0, busy}, 32'd1);
    chk("xfer_req", {31'd0, xfer_req}, {31'd0, exp_req});
    chk("xfer_data", {24'd0, xfer_data}, {24'd0, d});
    xfer_ack = exp_req;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    chk("xfer_done_latency", n, 32'd4);
    chk("xfer_cnt", {30'd0, xfer_cnt}, {30'd0, exp_cnt});
    chk("xfer_ready", {31'd0, src_ready}, 32'd1);
  endtask

  initial begin
    int n;
    bit seen;

    // Table: inputs {valid, data, ack}, expected {ready, req, xdata, done, busy, cnt}
    tbl[0]  = mk(1, 8'hA5, 0,  0, 1, 8'hA5, 0, 1, 2'd0);
    tbl[1]  = mk(1, 8'h11, 1,  0, 1, 8'hA5, 0, 1, 2'd0);
    tbl[2]  = mk(1, 8'h11, 1,  0, 1, 8'hA5, 0, 1, 2'd0);
    tbl[3]  = mk(1, 8'h11, 1,  0, 1, 8'hA5, 0, 1, 2'd0);
    tbl[4]  = mk(1, 8'h11, 1,  1, 1, 8'hA5, 1, 0, 2'd1);
    tbl[5]  = mk(1, 8'h11, 1,  0, 0, 8'h11, 0, 1, 2'd1);
    tbl[6]  = mk(1, 8'h22, 0,  0, 0, 8'h11, 0, 1, 2'd1);
    tbl[7]  = mk(1, 8'h22, 0,  0, 0, 8'h11, 0, 1, 2'd1);
    tbl[8]  = mk(1, 8'h22, 0,  0, 0, 8'h11, 0, 1, 2'd1);
    tbl[9]  = mk(1, 8'h22, 0,  1, 0, 8'h11, 1, 0, 2'd2);
    tbl[10] = mk(1, 8'h22, 0,  0, 1, 8'h22, 0, 1, 2'd2);
    tbl[11] = mk(1, 8'h33, 1,  0, 1, 8'h22, 0, 1, 2'd2);
    tbl[12] = mk(1, 8'h33, 1,  0, 1, 8'h22, 0, 1, 2'd2);
    tbl[13] = mk(1, 8'h33, 1,  0, 1, 8'h22, 0, 1, 2'd2);
    tbl[14] = mk(1, 8'h33, 1,  1, 1, 8'h22, 1, 0, 2'd3);
    tbl[15] = mk(1, 8'h33, 1,  0, 0, 8'h33, 0, 1, 2'd3);
    tbl[16] = mk(0, 8'h00, 0,  0, 0, 8'h33, 0, 1, 2'd3);
    tbl[17] = mk(0, 8'h00, 0,  0, 0, 8'h33, 0, 1, 2'd3);
    tbl[18] = mk(0, 8'h00, 0,  0, 0, 8'h33, 0, 1, 2'd3);
    tbl[19] = mk(0, 8'h00, 0,  1, 0, 8'h33, 1, 0, 2'd0);
    tbl[20] = mk(0, 8'h00, 0,  1, 0, 8'h33, 0, 0, 2'd0);

    rstn = 1'b0; src_valid = 1'b0; src_data = 8'h00; xfer_ack = 1'b0; err_clr = 1'b0;
    exp_req = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_ready", {31'd0, src_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, xfer_req}, 32'd0);
    chk("rst_data", {24'd0, xfer_data}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("rst_perr", {31'd0, proto_err}, 32'd0);
    chk("rst_cnt", {30'd0, xfer_cnt}, 32'd0);
    rstn = 1'b1;
    tick();

    // Single word then three words with echoing destination
    for (int i = 0; i < 21; i++) begin
      src_valid = tbl[i].v;
      src_data  = tbl[i].d;
      xfer_ack  = tbl[i].a;
      tick();
      chk($sformatf("v%0d_ready", i), {31'd0, src_ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("v%0d_req", i), {31'd0, xfer_req}, {31'd0, tbl[i].req});
      chk($sformatf("v%0d_data", i), {24'd0, xfer_data}, {24'd0, tbl[i].xd});
      chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, tbl[i].dn});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
      chk($sformatf("v%0d_cnt", i), {30'd0, xfer_cnt}, {30'd0, tbl[i].cnt});
      chk($sformatf("v%0d_errs", i), {30'd0, timeout_err, proto_err}, 32'd0);
    end
    exp_req = 1'b0;

    // Watchdog expiry with no ack
    src_valid = 1'b1; src_data = 8'h5A;
    tick();
    exp_req = ~exp_req;
    src_valid = 1'b0;
    repeat (7) tick();
    chk("wd_not_yet", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("wd_expired", {31'd0, timeout_err}, 32'd1);
    chk("wd_busy", {31'd0, busy}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_clr_loses", {31'd0, timeout_err}, 32'd1);
    xfer_ack = exp_req;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("wd_late_done", {31'd0, seen}, 32'd1);
    chk("wd_idle", {31'd0, busy}, 32'd0);
    chk("wd_sticky", {31'd0, timeout_err}, 32'd1);
    chk("wd_cnt", {30'd0, xfer_cnt}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_cleared", {31'd0, timeout_err}, 32'd0);

    // Completion on the same edge as expiry: completion wins
    src_valid = 1'b1; src_data = 8'h77;
    tick();
    exp_req = ~exp_req;
    src_valid = 1'b0;
    repeat (4) tick();
    xfer_ack = exp_req;
    repeat (3) tick();
    chk("tie_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("tie_done", {31'd0, done}, 32'd1);
    chk("tie_no_terr", {31'd0, timeout_err}, 32'd0);
    chk("tie_cnt", {30'd0, xfer_cnt}, 32'd2);

    // Stray ack while IDLE
    xfer_ack = ~exp_req;
    repeat (3) tick();
    chk("perr_not_yet", {31'd0, proto_err}, 32'd0);
    tick();
    chk("perr_set", {31'd0, proto_err}, 32'd1);
    chk("perr_ready", {31'd0, src_ready}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("perr_clr_loses", {31'd0, proto_err}, 32'd1);
    xfer_ack = exp_req;
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("perr_cleared", {31'd0, proto_err}, 32'd0);

    // Reset in the middle of a transfer
    src_valid = 1'b1; src_data = 8'hC3;
    tick();
    exp_req = ~exp_req;
    src_valid = 1'b0;
    repeat (2) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_req", {31'd0, xfer_req}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, src_ready}, 32'd1);
    chk("mrst_cnt", {30'd0, xfer_cnt}, 32'd0);
    xfer_ack = 1'b0;
    exp_req  = 1'b0;
    #2 rstn = 1'b1;
    tick();
    chk("mrst_perr", {31'd0, proto_err}, 32'd0);

    // Post-reset transfer, then counter wrap at CntWidth=2
    do_xfer(8'h3C, 2'd1);
    do_xfer(8'h01, 2'd2);
    do_xfer(8'hFE, 2'd3);
    do_xfer(8'h80, 2'd0);
    do_xfer(8'h7F, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
